// File: rtl/dac_writer.sv
// dac_writer: serial transmitter for a 12-bit SPI-style DAC (DAC7311-class).
//
// One sample is accepted per valid/ready handshake. It is sent as a 16-bit
// frame, MSB first: {mode[1:0], sample[11:0], 2'b00}. SYNC is low for the
// whole frame and is then held high for FRAME_GAP SCLK periods. The DAC
// samples DIN on SCLK falling edges. DIN changes only at SCLK period
// boundaries.
//
// Parameters:
//   CLOCK_DIV : clk cycles per SCLK period (power of two, >= 2)
//   FRAME_GAP : whole SCLK periods of SYNC-high after a frame (0 allowed)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   sample offered
//   in_ready   out  sample can be accepted (IDLE only)
//   in_data    in   12-bit unsigned sample
//   pd         in   2-bit power-down mode (only with DAC_WRITER_PD_EN)
//   dac_sclk   out  serial clock, idles high
//   dac_sync_n out  frame select, active low, idles high
//   dac_din    out  serial data
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse when a frame completes
//
// Optional feature: define DAC_WRITER_PD_EN to add the pd input. pd is
// latched at accept into frame bits [15:14]. Without the macro those bits
// are always 00.
module dac_writer #(
  parameter int CLOCK_DIV = 16,
  parameter int FRAME_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
`ifdef DAC_WRITER_PD_EN
  input  logic [1:0]  pd,
`endif
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        busy,
  output logic        done
);

  localparam int DW = (CLOCK_DIV > 2) ? $clog2(CLOCK_DIV) : 1;
  localparam int GW = (FRAME_GAP > 2) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [3:0]    bitcnt_q;
  logic [GW-1:0] gapcnt_q;
  // Bit 15 of the frame goes straight to DIN at accept, so only bits
  // [14:0] need to be held for shifting.
  logic [14:0]   shift_q;
  logic          sclk_q;
  logic          sync_n_q;
  logic          din_q;
  logic          done_q;
  logic          tick_s;
  logic [15:0]   frame_s;

  // Next divider value and end-of-SCLK-period strobe.
  assign div_d  = div_q + DW'(1);
  assign tick_s = &div_q;

`ifdef DAC_WRITER_PD_EN
  assign frame_s = {pd, in_data, 2'b00};
`else
  assign frame_s = {2'b00, in_data, 2'b00};
`endif

  // Handshake and status decode directly from the state register.
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_din    = din_q;
  assign done       = done_q;

  // Frame sequencer with registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitcnt_q <= 4'd0;
      gapcnt_q <= '0;
      shift_q  <= 15'd0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q    <= '0;
          sclk_q   <= 1'b1;
          sync_n_q <= 1'b1;
          din_q    <= 1'b0;
          if (in_valid) begin
            shift_q  <= frame_s[14:0];
            bitcnt_q <= 4'd0;
            sync_n_q <= 1'b0;
            din_q    <= frame_s[15];
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          div_q  <= div_d;
          // SCLK is high for the first half of each period and falls
          // mid-period, where the DAC samples DIN.
          sclk_q <= ~div_d[DW-1];
          if (tick_s) begin
            if (bitcnt_q != 4'd15) begin
              shift_q  <= {shift_q[13:0], 1'b0};
              din_q    <= shift_q[14];
              bitcnt_q <= bitcnt_q + 4'd1;
            end else begin
              sclk_q   <= 1'b1;
              sync_n_q <= 1'b1;
              din_q    <= 1'b0;
              done_q   <= 1'b1;
              gapcnt_q <= '0;
              state_q  <= (FRAME_GAP > 0) ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          // The divider keeps running so the gap is a whole number of
          // SCLK periods. gapcnt_q counts the elapsed periods.
          div_q    <= div_d;
          sclk_q   <= 1'b1;
          sync_n_q <= 1'b1;
          din_q    <= 1'b0;
          if (tick_s) begin
            if (gapcnt_q == GAP_LAST) begin
              state_q <= IDLE;
            end else begin
              gapcnt_q <= gapcnt_q + GW'(1);
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          sclk_q   <= 1'b1;
          sync_n_q <= 1'b1;
          din_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
